demux_1to2_stream: RTL
======================

Name: demux_1to2_stream

Overview:
- Buffered 1-to-2 demultiplexer: the inverse of the 2-to-1 data selector.
- Routes one valid/ready input stream to one of two output streams, chosen per word by Selector.
- Each output has a one-entry holding register, so either consumer can stall without corrupting the other.
- Sits between a single datapath producer and two consumers (e.g. two register-file/memory write ports); also counts delivered words per output.

Parameters:
WORD_LENGTH, 32, data width of input and both outputs
COUNT_WIDTH, 8, width of each per-output delivered-word counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
Selector  input  1  destination of current input word: 0 -> output 0, 1 -> output 1
In_Valid  input  1  input word present
In_Data  input  WORD_LENGTH  input word
In_Ready  output  1  block accepts input word this cycle
Out0_Valid  output  1  output 0 holds a word
Out0_Data  output  WORD_LENGTH  output 0 word
Out0_Ready  input  1  consumer 0 takes word this cycle
Out1_Valid  output  1  output 1 holds a word
Out1_Data  output  WORD_LENGTH  output 1 word
Out1_Ready  input  1  consumer 1 takes word this cycle
Count0  output  COUNT_WIDTH  words delivered on output 0
Count1  output  COUNT_WIDTH  words delivered on output 1

Behaviour:
- Reset (reset=0, asynchronous, no clock needed): Out0_Valid=Out1_Valid=0, Out0_Data=Out1_Data=0, Count0=Count1=0. In_Ready then evaluates to 1.
- Reset mid-operation discards any held word; no partial transfer survives.
- Each output x has a 2-state FSM: EMPTY (Outx_Valid=0) and FULL (Outx_Valid=1). Outx_Data is registered.
- In_Ready is combinational:
  - Selector=0: In_Ready = !Out0_Valid || Out0_Ready.
  - Selector=1: In_Ready = !Out1_Valid || Out1_Ready.
- Accept = In_Valid && In_Ready. On an accepting edge, In_Data loads into the selected output register and its Valid is set.
- The non-selected output is unaffected by an accept.
- Output handshake = Outx_Valid && Outx_Ready.
- FSM transitions for output x on each rising edge:
  - EMPTY + accept targeting x -> FULL.
  - FULL + handshake + accept targeting x -> FULL with new data (back-to-back, full throughput).
  - FULL + handshake, no accept -> EMPTY; data register holds its last value.
  - FULL, no handshake -> FULL; Outx_Data must stay stable.
- Latency: a word accepted at edge n is visible on Outx_Valid/Outx_Data after edge n, i.e. one cycle.
- Throughput: one word per cycle, even when alternating outputs, provided consumers are ready.
- Both outputs may complete handshakes in the same cycle; each proceeds independently.
- Ordering: words to the same output leave in arrival order. No ordering is guaranteed between outputs.
- Selector and In_Data matter only when In_Valid=1. While In_Valid=1 and In_Ready=0, the producer holds Selector and In_Data stable.
- Counters: Countx increments by 1 on each output-x handshake and wraps from 2^COUNT_WIDTH-1 to 0. The counters are never cleared except by reset.
- No combinational path from In_Valid or In_Data to any Outx signal.

Test Plan:
- Reset then idle with Out0_Ready=Out1_Ready=1 -> all Valid=0, Data=0, Counts=0, In_Ready=1. Assert reset mid-stream with Out0 FULL -> Out0_Valid drops to 0 immediately, without a clock edge.
- Route 0xA5A5_0001 with Selector=0, then 0x5A5A_0002 with Selector=1, consumers ready -> each word appears on the correct output exactly one cycle after accept. Count0=1, Count1=1; other output stays Valid=0.
- Out0_Ready=0 with Out0 FULL (0x11), present Selector=0 word 0x22 -> In_Ready=0 and Out0_Data holds 0x11. Present Selector=1 word 0x33 -> accepted on Out1 while Out0 stalls. Raise Out0_Ready -> 0x11 delivered, then 0x22.
- Stream 8 consecutive words to output 1 with Out1_Ready held 1 -> one word per cycle, In_Ready never drops, Count1=8, order preserved.
- COUNT_WIDTH=8: deliver 256 words to output 0 -> Count0 goes 255 then 0. Count1 unchanged.
- Random Selector/Valid/Ready traffic, 10k cycles, against a scoreboard -> no loss, duplication or misrouting. Per-output order preserved and counts match the scoreboard modulo 2^COUNT_WIDTH.

Source files
------------

// File: rtl/demux_1to2_stream.sv
// Buffered 1-to-2 stream demultiplexer: routes each input word to output 0 or 1 by Selector.
// Each output owns a one-entry holding register and a wrapping delivered-word counter.
module demux_1to2_stream #(
    parameter int WORD_LENGTH = 32,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Selector,
    input  logic                   In_Valid,
    input  logic [WORD_LENGTH-1:0] In_Data,
    output logic                   In_Ready,
    output logic                   Out0_Valid,
    output logic [WORD_LENGTH-1:0] Out0_Data,
    input  logic                   Out0_Ready,
    output logic                   Out1_Valid,
    output logic [WORD_LENGTH-1:0] Out1_Data,
    input  logic                   Out1_Ready,
    output logic [COUNT_WIDTH-1:0] Count0,
    output logic [COUNT_WIDTH-1:0] Count1
);

    // Valid/ready: a word moves on a rising edge where both valid and ready are high;
    // valid never depends on ready, and a held word stays stable until it is taken.
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t state0_q, state0_d;
    state_t state1_q, state1_d;
    logic   accept, accept0, accept1;
    logic   hs0, hs1;

    // The output state doubles as the valid flag, so the FSM state is directly observable.
    assign Out0_Valid = (state0_q == FULL);
    assign Out1_Valid = (state1_q == FULL);

    assign hs0 = Out0_Valid && Out0_Ready;
    assign hs1 = Out1_Valid && Out1_Ready;

    // Ready looks only at the selected slot; a slot being drained this edge can take a new word.
    assign In_Ready = Selector ? (!Out1_Valid || Out1_Ready) : (!Out0_Valid || Out0_Ready);

    assign accept  = In_Valid && In_Ready;
    assign accept0 = accept && !Selector;
    assign accept1 = accept &&  Selector;

    always_comb begin
        state0_d = state0_q;
        state1_d = state1_q;
        case (state0_q)
            EMPTY:   if (accept0) state0_d = FULL;
            FULL:    if (hs0 && !accept0) state0_d = EMPTY;
            default: state0_d = EMPTY;
        endcase
        case (state1_q)
            EMPTY:   if (accept1) state1_d = FULL;
            FULL:    if (hs1 && !accept1) state1_d = EMPTY;
            default: state1_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state0_q <= EMPTY;
            state1_q <= EMPTY;
        end else begin
            state0_q <= state0_d;
            state1_q <= state1_d;
        end
    end

    // Data registers load only on accept, so a drained slot keeps showing its last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Out0_Data <= '0;
            Out1_Data <= '0;
        end else begin
            if (accept0) Out0_Data <= In_Data;
            if (accept1) Out1_Data <= In_Data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Count0 <= '0;
            Count1 <= '0;
        end else begin
            if (hs0) Count0 <= Count0 + COUNT_WIDTH'(1);
            if (hs1) Count1 <= Count1 + COUNT_WIDTH'(1);
        end
    end

endmodule
